// File: rtl/ysyx_24080014_pkg.sv
// Shared constants for the NPC register file / M-mode CSR block:
// CSR addresses, CSR op encoding, mstatus layout and ID values.
package ysyx_24080014_pkg;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] MVENDORID     = 32'h7973_7978;
   localparam logic [31:0] MARCHID       = 32'd24080014;

   function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                             input logic [31:0] operand);
      logic [31:0] res;
      case (op)
         CSR_RW:  res = operand;
         CSR_RS:  res = old | operand;
         CSR_RC:  res = old & ~operand;
         default: res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ysyx_24080014_regfile_csr_if.sv
// Decode/execute-side bus of the register file / CSR block.
// master = core pipeline, slave = ysyx_24080014_regfile_csr.
interface ysyx_24080014_regfile_csr_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
);
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0]   rs_addr;
   logic [NRD*XLEN-1:0] rs_data;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic [1:0]          csr_op;
   logic [11:0]         csr_addr;
   logic [XLEN-1:0]     csr_wdata;
   logic [XLEN-1:0]     csr_rdata;
   logic                csr_illegal;
   logic                trap_valid;
   logic [XLEN-1:0]     trap_cause;
   logic [XLEN-1:0]     trap_pc;
   logic                mret_valid;
   logic                instret_inc;
   logic                redirect_valid;
   logic [XLEN-1:0]     redirect_pc;

   modport master (
      output rs_addr, wr_en, wr_addr, wr_data, csr_op, csr_addr, csr_wdata,
             trap_valid, trap_cause, trap_pc, mret_valid, instret_inc,
      input  rs_data, csr_rdata, csr_illegal, redirect_valid, redirect_pc
   );

   modport slave (
      input  rs_addr, wr_en, wr_addr, wr_data, csr_op, csr_addr, csr_wdata,
             trap_valid, trap_cause, trap_pc, mret_valid, instret_inc,
      output rs_data, csr_rdata, csr_illegal, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ysyx_24080014_csr_file.sv
// M-mode CSRs, 64-bit cycle/instret counters, ecall/mret sequencing and
// the registered one-cycle PC redirect. Priority: trap > mret > CSR write.
module ysyx_24080014_csr_file
   import ysyx_24080014_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret_valid,
   input  logic            instret_inc,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [63:0]     mcycle_q, mcycle_d;
   logic [63:0]     minstret_q, minstret_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   csr_op_e         op_s;
   logic            mapped_s;
   logic            ro_s;
   logic            wr_req_s;
   logic            illegal_s;
   logic            do_write_s;
   logic [XLEN-1:0] old_s;
   logic [XLEN-1:0] new_s;

   assign op_s = csr_op_e'(csr_op);

   // Address decode and old-value read mux
   always_comb begin
      mapped_s = 1'b1;
      ro_s     = 1'b0;
      old_s    = '0;
      case (csr_addr)
         CSR_MSTATUS:   old_s = mstatus_q;
         CSR_MTVEC:     old_s = mtvec_q;
         CSR_MEPC:      old_s = mepc_q;
         CSR_MCAUSE:    old_s = mcause_q;
         CSR_MCYCLE:    old_s = mcycle_q[31:0];
         CSR_MCYCLEH:   old_s = mcycle_q[63:32];
         CSR_MINSTRET:  old_s = minstret_q[31:0];
         CSR_MINSTRETH: old_s = minstret_q[63:32];
         CSR_MVENDORID: begin
            old_s = MVENDORID;
            ro_s  = 1'b1;
         end
         CSR_MARCHID: begin
            old_s = MARCHID;
            ro_s  = 1'b1;
         end
         default:       mapped_s = 1'b0;
      endcase
   end

   // RS/RC with a zero operand is a pure read and never modifies state
   assign wr_req_s   = (op_s == CSR_RW) ||
                       (((op_s == CSR_RS) || (op_s == CSR_RC)) && (csr_wdata != '0));
   assign illegal_s  = ((op_s != CSR_NONE) && !mapped_s) || (ro_s && wr_req_s);
   assign do_write_s = wr_req_s && mapped_s && !ro_s && !trap_valid && !mret_valid;
   assign new_s      = csr_apply(op_s, old_s, csr_wdata);

   // Next-state for CSRs, counters and redirect
   always_comb begin
      mstatus_d        = mstatus_q;
      mtvec_d          = mtvec_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      mcycle_d         = mcycle_q + 64'd1;
      minstret_d       = minstret_q + {63'd0, instret_inc};
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      if (trap_valid) begin
         mepc_d                 = {trap_pc[XLEN-1:2], 2'b00};
         mcause_d               = trap_cause;
         mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
         mstatus_d[MSTATUS_MIE]  = 1'b0;
         redirect_valid_d       = 1'b1;
         redirect_pc_d          = {mtvec_q[XLEN-1:2], 2'b00};
      end else if (mret_valid) begin
         mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
         mstatus_d[MSTATUS_MPIE] = 1'b1;
         redirect_valid_d       = 1'b1;
         redirect_pc_d          = mepc_q;
      end else if (do_write_s) begin
         case (csr_addr)
            CSR_MSTATUS:   mstatus_d  = (new_s & MSTATUS_WMASK) | MSTATUS_RST;
            CSR_MTVEC:     mtvec_d    = {new_s[XLEN-1:2], 2'b00};
            CSR_MEPC:      mepc_d     = {new_s[XLEN-1:2], 2'b00};
            CSR_MCAUSE:    mcause_d   = new_s;
            CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_s};
            CSR_MCYCLEH:   mcycle_d   = {new_s, mcycle_q[31:0]};
            CSR_MINSTRET:  minstret_d = {minstret_q[63:32], new_s};
            CSR_MINSTRETH: minstret_d = {new_s, minstret_q[31:0]};
            default:       mcause_d   = mcause_q;
         endcase
      end else begin
         mstatus_d = mstatus_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_q        <= MSTATUS_RST;
         mtvec_q          <= '0;
         mepc_q           <= '0;
         mcause_q         <= '0;
         mcycle_q         <= 64'd0;
         minstret_q       <= 64'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         mstatus_q        <= mstatus_d;
         mtvec_q          <= mtvec_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         mcycle_q         <= mcycle_d;
         minstret_q       <= minstret_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign csr_rdata      = illegal_s ? '0 : old_s;
   assign csr_illegal    = illegal_s;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

// File: rtl/ysyx_24080014_regfile_csr.sv
// GPR array with NRD combinational read ports plus the M-mode CSR file.
// Define YSYX_24080014_GPR_BYPASS_EN to forward same-cycle writeback data to reads.
module ysyx_24080014_regfile_csr
   import ysyx_24080014_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
) (
   input logic                    clk,
   input logic                    rst_n,
   ysyx_24080014_regfile_csr_if.slave bus
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0]     gpr_q [NREG];
   logic [XLEN-1:0]     gpr_d [NREG];
   logic [NRD*XLEN-1:0] rs_data_s;

   // Writeback; x0 is never stored
   always_comb begin
      gpr_d = gpr_q;
      if (bus.wr_en && (bus.wr_addr != AW'(0))) begin
         gpr_d[bus.wr_addr] = bus.wr_data;
      end else begin
         gpr_d = gpr_q;
      end
   end

   // GPR storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpr_q <= '{default: '0};
      end else begin
         gpr_q <= gpr_d;
      end
   end

   // Read ports
   always_comb begin
      rs_data_s = '0;
      for (int k = 0; k < NRD; k++) begin
         if (bus.rs_addr[k*AW +: AW] == AW'(0)) begin
            rs_data_s[k*XLEN +: XLEN] = '0;
`ifdef YSYX_24080014_GPR_BYPASS_EN
         end else if (bus.wr_en && (bus.rs_addr[k*AW +: AW] == bus.wr_addr)) begin
            rs_data_s[k*XLEN +: XLEN] = bus.wr_data;
`endif
         end else begin
            rs_data_s[k*XLEN +: XLEN] = gpr_q[bus.rs_addr[k*AW +: AW]];
         end
      end
   end

   assign bus.rs_data = rs_data_s;

   ysyx_24080014_csr_file #(
      .XLEN(XLEN)
   ) u_csr_file (
      .clk           (clk),
      .rst_n         (rst_n),
      .csr_op        (bus.csr_op),
      .csr_addr      (bus.csr_addr),
      .csr_wdata     (bus.csr_wdata),
      .csr_rdata     (bus.csr_rdata),
      .csr_illegal   (bus.csr_illegal),
      .trap_valid    (bus.trap_valid),
      .trap_cause    (bus.trap_cause),
      .trap_pc       (bus.trap_pc),
      .mret_valid    (bus.mret_valid),
      .instret_inc   (bus.instret_inc),
      .redirect_valid(bus.redirect_valid),
      .redirect_pc   (bus.redirect_pc)
   );

endmodule

// File: tb/tb_ysyx_24080014_regfile_csr.sv
// Directed + random bench for ysyx_24080014_regfile_csr against a behavioural model.
module tb_ysyx_24080014_regfile_csr;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ysyx_24080014_regfile_csr_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

   ysyx_24080014_regfile_csr #(.XLEN(32), .NREG(32), .NRD(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int nvec = 0;
   int nfail = 0;

   logic [31:0] m_gpr [32];
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_rpc;
   logic [63:0] m_cyc, m_ins;
   logic        m_rv;

   logic [11:0] addrs [12] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80,
                               12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'h7C0, 12'h301};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_mstatus = 32'h0000_1800;
      m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
      m_cyc = 64'd0; m_ins = 64'd0;
      m_rv = 1'b0; m_rpc = 32'd0;
   endtask

   function automatic void m_csr(input logic [11:0] a, output logic [31:0] v,
                                 output bit mapped, output bit ro);
      mapped = 1'b1; ro = 1'b0; v = 32'd0;
      case (a)
         12'h300: v = m_mstatus;
         12'h305: v = m_mtvec;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hB00: v = m_cyc[31:0];
         12'hB80: v = m_cyc[63:32];
         12'hB02: v = m_ins[31:0];
         12'hB82: v = m_ins[63:32];
         12'hF11: begin v = 32'h7973_7978; ro = 1'b1; end
         12'hF12: begin v = 32'd24080014; ro = 1'b1; end
         default: mapped = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_rs(input int k);
      logic [4:0] a;
      a = bus.rs_addr[k*5 +: 5];
      if (a == 5'd0) return 32'd0;
`ifdef YSYX_24080014_GPR_BYPASS_EN
      if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
`endif
      return m_gpr[a];
   endfunction

   function automatic bit m_wreq();
      return (bus.csr_op == 2'b01) || (bus.csr_op[1] && bus.csr_wdata != 32'd0);
   endfunction

   // Advance model by one clock edge using the inputs presented before it
   task automatic m_update();
      logic [31:0] v, nv;
      logic [63:0] c, n;
      bit mapped, ro;
      m_csr(bus.csr_addr, v, mapped, ro);
      case (bus.csr_op)
         2'b01:   nv = bus.csr_wdata;
         2'b10:   nv = v | bus.csr_wdata;
         default: nv = v & ~bus.csr_wdata;
      endcase
      c = m_cyc + 64'd1;
      n = m_ins + (bus.instret_inc ? 64'd1 : 64'd0);
      m_rv = bus.trap_valid | bus.mret_valid;
      if (bus.trap_valid) begin
         m_mepc = bus.trap_pc & ~32'd3;
         m_mcause = bus.trap_cause;
         m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
         m_rpc = m_mtvec & ~32'd3;
      end else if (bus.mret_valid) begin
         m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
         m_rpc = m_mepc;
      end else if (m_wreq() && mapped && !ro) begin
         case (bus.csr_addr)
            12'h300: m_mstatus = 32'h1800 | (nv & 32'h88);
            12'h305: m_mtvec = nv & ~32'd3;
            12'h341: m_mepc = nv & ~32'd3;
            12'h342: m_mcause = nv;
            12'hB00: c = {m_cyc[63:32], nv};
            12'hB80: c = {nv, m_cyc[31:0]};
            12'hB02: n = {m_ins[63:32], nv};
            12'hB82: n = {nv, m_ins[31:0]};
            default: ;
         endcase
      end
      m_cyc = c;
      m_ins = n;
      if (bus.wr_en && bus.wr_addr != 5'd0) m_gpr[bus.wr_addr] = bus.wr_data;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] v;
      bit mapped, ro, ill;
      m_csr(bus.csr_addr, v, mapped, ro);
      ill = (bus.csr_op != 2'b00 && !mapped) || (ro && m_wreq());
      chk({tag, "_rs0"}, bus.rs_data[31:0], m_rs(0));
      chk({tag, "_rs1"}, bus.rs_data[63:32], m_rs(1));
      chk({tag, "_ill"}, {31'd0, bus.csr_illegal}, {31'd0, ill});
      chk({tag, "_rdata"}, bus.csr_rdata, ill ? 32'd0 : v);
      chk({tag, "_rv"}, {31'd0, bus.redirect_valid}, {31'd0, m_rv});
      chk({tag, "_rpc"}, bus.redirect_pc, m_rpc);
   endtask

   task automatic idle();
      bus.rs_addr = 10'd0; bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
      bus.csr_op = 2'b00; bus.csr_addr = 12'h000; bus.csr_wdata = 32'd0;
      bus.trap_valid = 1'b0; bus.trap_cause = 32'd0; bus.trap_pc = 32'd0;
      bus.mret_valid = 1'b0; bus.instret_inc = 1'b0;
   endtask

   task automatic rd_csr(input logic [11:0] a);
      idle();
      bus.csr_addr = a;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      m_update();
      #1;
   endtask

   initial begin
      logic [4:0] ra0, ra1;
      int r;
      m_reset();
      idle();
      bus.rs_addr = {5'd7, 5'd5};
      bus.csr_addr = 12'h300;
      #17;
      check_all("rst");
      chk("rst_mstatus", bus.csr_rdata, 32'h0000_1800);
      chk("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
      rst_n = 1'b1;

      // GPR write / x0 / same-cycle read
      idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEAD_BEEF;
      bus.rs_addr = {5'd0, 5'd5};
      #1; check_all("gw1");
`ifdef YSYX_24080014_GPR_BYPASS_EN
      chk("same_cycle_x5", bus.rs_data[31:0], 32'hDEAD_BEEF);
`else
      chk("same_cycle_x5", bus.rs_data[31:0], 32'd0);
`endif
      step();
      idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
      bus.rs_addr = {5'd0, 5'd5};
      #1; check_all("gw2");
      chk("x5_after", bus.rs_data[31:0], 32'hDEAD_BEEF);
      step();
      idle(); bus.rs_addr = {5'd0, 5'd5};
      #1; check_all("gw3");
      chk("x0_zero", bus.rs_data[63:32], 32'd0);
      step();

      // mtvec + trap
      idle(); bus.csr_op = 2'b01; bus.csr_addr = 12'h305; bus.csr_wdata = 32'h8000_0103;
      #1; check_all("mtvec_w"); step();
      idle(); bus.trap_valid = 1'b1; bus.trap_pc = 32'h8000_0040; bus.trap_cause = 32'd11;
      bus.csr_addr = 12'h305;
      #1; check_all("trap1");
      chk("mtvec_rd", bus.csr_rdata, 32'h8000_0100);
      step();
      rd_csr(12'h341); check_all("post_trap");
      chk("redir_v", {31'd0, bus.redirect_valid}, 32'd1);
      chk("redir_pc", bus.redirect_pc, 32'h8000_0100);
      chk("mepc", bus.csr_rdata, 32'h8000_0040);
      step();
      rd_csr(12'h342); check_all("mcause_rd");
      chk("mcause", bus.csr_rdata, 32'd11);
      chk("redir_drop", {31'd0, bus.redirect_valid}, 32'd0);
      step();

      // MIE set, trap, mret
      idle(); bus.csr_op = 2'b10; bus.csr_addr = 12'h300; bus.csr_wdata = 32'h8;
      #1; check_all("rs_mie"); step();
      rd_csr(12'h300); check_all("mst1");
      chk("mstatus_mie", bus.csr_rdata, 32'h1808);
      step();
      idle(); bus.trap_valid = 1'b1; bus.trap_pc = 32'h8000_0040; bus.trap_cause = 32'd11;
      #1; check_all("trap2"); step();
      rd_csr(12'h300); check_all("mst2");
      chk("mstatus_trap", bus.csr_rdata, 32'h1880);
      bus.mret_valid = 1'b1;
      step();
      rd_csr(12'h300); check_all("mst3");
      chk("mret_pc", bus.redirect_pc, 32'h8000_0040);
      chk("mstatus_mret", bus.csr_rdata, 32'h1888);
      step();

      // trap beats CSR write; back-to-back traps
      idle(); bus.trap_valid = 1'b1; bus.trap_pc = 32'h8000_0044; bus.trap_cause = 32'd11;
      bus.csr_op = 2'b01; bus.csr_addr = 12'h341; bus.csr_wdata = 32'h55;
      #1; check_all("trap_vs_w"); step();
      idle(); bus.trap_valid = 1'b1; bus.trap_pc = 32'h8000_0044; bus.trap_cause = 32'd2;
      bus.csr_addr = 12'h341;
      #1; check_all("b2b");
      chk("mepc_trap_wins", bus.csr_rdata, 32'h8000_0044);
      step();
      rd_csr(12'h342); check_all("b2b2");
      chk("b2b_pulse", {31'd0, bus.redirect_valid}, 32'd1);
      step();

      // read-only / unmapped
      idle(); bus.csr_op = 2'b01; bus.csr_addr = 12'hF11; bus.csr_wdata = 32'd1;
      #1; check_all("ro_rw");
      chk("ro_rw_ill", {31'd0, bus.csr_illegal}, 32'd1);
      chk("ro_rw_data", bus.csr_rdata, 32'd0);
      step();
      idle(); bus.csr_op = 2'b10; bus.csr_addr = 12'hF11;
      #1; check_all("ro_rs0");
      chk("ro_rs0_data", bus.csr_rdata, 32'h7973_7978);
      step();
      idle(); bus.csr_op = 2'b01; bus.csr_addr = 12'h7C0; bus.csr_wdata = 32'd3;
      #1; check_all("unmapped");
      chk("unmapped_ill", {31'd0, bus.csr_illegal}, 32'd1);
      step();

      // counter rollover and write-over-increment
      idle(); bus.csr_op = 2'b01; bus.csr_addr = 12'hB00; bus.csr_wdata = 32'hFFFF_FFFF;
      #1; check_all("cyc_lo"); step();
      idle(); bus.csr_op = 2'b01; bus.csr_addr = 12'hB80; bus.csr_wdata = 32'hFFFF_FFFF;
      #1; check_all("cyc_hi"); step();
      rd_csr(12'hB80); check_all("cyc_max");
      chk("cyc_max_hi", bus.csr_rdata, 32'hFFFF_FFFF);
      step();
      rd_csr(12'hB00); check_all("cyc_wrap");
      chk("cyc_wrap_lo", bus.csr_rdata, 32'd0);
      step();
      rd_csr(12'hB80); check_all("cyc_wrap_h");
      chk("cyc_wrap_hi", bus.csr_rdata, 32'd0);
      step();
      idle(); bus.csr_op = 2'b01; bus.csr_addr = 12'hB02; bus.csr_wdata = 32'd5;
      bus.instret_inc = 1'b1;
      #1; check_all("ins_w"); step();
      rd_csr(12'hB02); check_all("ins_rd");
      chk("minstret_5", bus.csr_rdata, 32'd5);
      step();

      // asynchronous reset with a redirect pending
      idle(); bus.trap_valid = 1'b1; bus.trap_pc = 32'h8000_0080; bus.trap_cause = 32'd11;
      #1; check_all("pre_rst"); step();
      idle(); bus.rs_addr = {5'd0, 5'd5}; bus.csr_addr = 12'h300;
      rst_n = 1'b0;
      #1;
      m_reset();
      check_all("mid_rst");
      chk("mid_rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("mid_rst_x5", bus.rs_data[31:0], 32'd0);
      rst_n = 1'b1;

      // random traffic
      for (int i = 0; i < 300; i++) begin
         idle();
         bus.wr_en = 1'($urandom_range(0, 1));
         bus.wr_addr = 5'($urandom_range(0, 31));
         bus.wr_data = $urandom;
         ra0 = 5'($urandom_range(0, 31));
         ra1 = ($urandom_range(0, 1) == 0) ? bus.wr_addr : 5'($urandom_range(0, 31));
         bus.rs_addr = {ra1, ra0};
         bus.csr_op = 2'($urandom_range(0, 3));
         bus.csr_addr = addrs[$urandom_range(0, 11)];
         bus.csr_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         r = $urandom_range(0, 15);
         bus.trap_valid = (r == 0) || (r == 2);
         bus.mret_valid = (r == 1) || (r == 2);
         bus.trap_cause = $urandom;
         bus.trap_pc = $urandom;
         bus.instret_inc = 1'($urandom_range(0, 1));
         #1;
         check_all("rnd");
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
